// File: rtl/cpu_pkg.sv
// Shared CPU package: core-count default, core-index width helper, the
// data-memory arbiter FSM state type and its debug view.
//   CORES_DEF  : default number of requesting cores
//   idx_w()    : core-index width, $clog2(n) with a floor of 1 bit
//   arb_state_t: IDLE (nothing in flight) / ACCESS (issued last cycle)
//   arb_dbg_t  : state, round-robin pointer and in-flight mask, sized for
//                the largest legal core count (8)
package cpu_pkg;

  localparam int CORES_DEF = 4;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CORE_IDX_W = idx_w(CORES_DEF);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } arb_state_t;

  typedef struct packed {
    arb_state_t state;
    logic [2:0] rr_ptr;
    logic [7:0] inflight;
  } arb_dbg_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle between the cores, the arbiter and the single-ported data memory.
//   req/we/addr/wdata : per-core access request (from cores)
//   ack/rdata/stall   : per-core completion pulse, read data, shared stall
//   mem_*             : memory strobe, write enable, address, data in/out
// Handshake: a core raises req[i] with we/addr/wdata and holds all of them
// stable until the cycle in which ack[i] is high; ack[i] is a one-cycle
// completion pulse, rdata is valid only in that cycle for a read, and the
// core drops req[i] in the next cycle unless it starts a new access there.
// mem_rdata is registered by the memory one cycle after mem_en.
// Modports: slave = arbiter view, master = cores plus memory view.
interface dmem_arbiter_if #(
  parameter int CORES  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic [CORES-1:0]             req;
  logic [CORES-1:0]             we;
  logic [CORES-1:0][ADDR_W-1:0] addr;
  logic [CORES-1:0][DATA_W-1:0] wdata;
  logic [CORES-1:0]             ack;
  logic [DATA_W-1:0]            rdata;
  logic                         stall;
  logic                         mem_en;
  logic                         mem_we;
  logic [ADDR_W-1:0]            mem_addr;
  logic [DATA_W-1:0]            mem_wdata;
  logic [DATA_W-1:0]            mem_rdata;

  modport slave (
    input  req, we, addr, wdata, mem_rdata,
    output ack, rdata, stall, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req, we, addr, wdata, mem_rdata,
    input  ack, rdata, stall, mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/dmem_arbiter_rr_picker.sv
// Combinational round-robin picker: returns the first set bit of eligible
// at or above rr_ptr, wrapping from CORES-1 back to 0.
//   eligible : candidate cores
//   rr_ptr   : search start index
//   valid    : at least one candidate
//   winner   : index of the chosen core (0 when not valid)
module rr_picker
  import cpu_pkg::*;
#(
  parameter  int CORES = CORES_DEF,
  localparam int IW    = idx_w(CORES)
) (
  input  logic [CORES-1:0] eligible,
  input  logic [IW-1:0]    rr_ptr,
  output logic             valid,
  output logic [IW-1:0]    winner
);

  always_comb begin
    logic [IW:0]   sum;
    logic [IW-1:0] idx;
    valid  = 1'b0;
    winner = '0;
    sum    = '0;
    idx    = '0;
    for (int i = 0; i < CORES; i++) begin
      // One extra bit keeps rr_ptr + i from overflowing before the wrap.
      sum = (IW+1)'(rr_ptr) + (IW+1)'(i);
      if (sum >= (IW+1)'(CORES)) begin
        sum = sum - (IW+1)'(CORES);
      end
      idx = sum[IW-1:0];
      if (!valid && eligible[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: serialises per-core accesses onto one single-ported
// memory. The winner of each cycle is driven straight onto the memory bus
// (same-cycle issue); its ack and read data appear in the next cycle.
//   clk, reset : clock, synchronous active-high reset
//   bus        : core request/ack and memory signals (slave modport)
//   dbg        : FSM state, round-robin pointer and in-flight mask
module dmem_arbiter
  import cpu_pkg::*;
#(
  parameter int CORES  = CORES_DEF,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus,
  output arb_dbg_t       dbg
);

  localparam int IW = idx_w(CORES);

  arb_state_t        state;
  logic [IW-1:0]     rr_ptr;
  logic [IW-1:0]     win_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic [CORES-1:0]  inflight_mask;
  logic [CORES-1:0]  eligible;
  logic              issue;
  logic [IW-1:0]     pick_idx;
  logic [IW-1:0]     rr_next;
  logic [IW:0]       rr_sum;

  // The core issued last cycle is still waiting for its ack and keeps req
  // high, so it must be masked out or it would be issued twice.
  assign inflight_mask = (state == ACCESS) ? (CORES'(1) << win_q) : '0;

  // Masking the eligible set during reset blocks issue without touching
  // the picker.
  assign eligible = reset ? '0 : (bus.req & ~inflight_mask);

  rr_picker #(.CORES(CORES)) u_picker (
    .eligible (eligible),
    .rr_ptr   (rr_ptr),
    .valid    (issue),
    .winner   (pick_idx)
  );

  assign rr_sum  = (IW+1)'(pick_idx) + (IW+1)'(1);
  assign rr_next = (rr_sum >= (IW+1)'(CORES)) ? '0 : rr_sum[IW-1:0];

  assign bus.mem_en    = issue;
  assign bus.mem_we    = issue & bus.we[pick_idx];
  assign bus.mem_addr  = issue ? bus.addr[pick_idx]  : addr_q;
  assign bus.mem_wdata = issue ? bus.wdata[pick_idx] : wdata_q;

  // Reset during ACCESS abandons the in-flight access, so its ack is gated.
  assign bus.ack   = reset ? '0 : inflight_mask;
  assign bus.rdata = (|bus.ack) ? bus.mem_rdata : '0;
  assign bus.stall = ~reset & (|(bus.req & ~bus.ack));

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      win_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state <= issue ? ACCESS : IDLE;
      if (issue) begin
        win_q   <= pick_idx;
        rr_ptr  <= rr_next;
        addr_q  <= bus.addr[pick_idx];
        wdata_q <= bus.wdata[pick_idx];
      end
    end
  end

  assign dbg.state    = state;
  assign dbg.rr_ptr   = 3'(rr_ptr);
  assign dbg.inflight = 8'(inflight_mask);

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
  import cpu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.CORES(4), .ADDR_W(32), .DATA_W(32)) bus ();
  dmem_arbiter_if #(.CORES(1), .ADDR_W(32), .DATA_W(32)) bus1 ();
  arb_dbg_t dbg;
  arb_dbg_t dbg1;

  dmem_arbiter #(.CORES(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .bus(bus), .dbg(dbg)
  );

  dmem_arbiter #(.CORES(1), .ADDR_W(32), .DATA_W(32)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1), .dbg(dbg1)
  );

  // ---------------- memory models ----------------
  logic [31:0] mem [0:255];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[4] <= 32'hDEADBEEF;
      bus.mem_rdata <= 32'h0;
    end else if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
      bus.mem_rdata <= mem[bus.mem_addr[9:2]];
    end
  end

  always @(posedge clk) begin
    if (reset) bus1.mem_rdata <= 32'h0;
    else if (bus1.mem_en) bus1.mem_rdata <= 32'hA500_0000 | bus1.mem_addr;
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive_edge();
    reset = 1'b1;
    drive_edge();
    reset = 1'b0;
  endtask

  task automatic set_core(input int c, input bit w, input logic [31:0] a, input logic [31:0] d);
    bus.req[2'(c)]   = 1'b1;
    bus.we[2'(c)]    = w;
    bus.addr[2'(c)]  = a;
    bus.wdata[2'(c)] = d;
  endtask

  function automatic logic [3:0] onehot(input int c);
    logic [3:0] v;
    v = '0;
    if (c >= 0) v[2'(c)] = 1'b1;
    return v;
  endfunction

  typedef struct {
    int          core;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_ack;
  } vec_t;

  vec_t vecs[5];

  // reference model state for the random phase
  int          m_ptr;
  int          m_prev;
  bit          m_prev_we;
  logic [31:0] m_last_addr;
  logic [31:0] m_last_wdata;
  logic [31:0] model_mem [0:7];
  int          skips [4];
  int          max_skip;
  logic [3:0]  ack_seen;

  initial begin
    bus.req = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0;
    bus1.req = '0; bus1.we = '0; bus1.addr = '0; bus1.wdata = '0;

    vecs[0] = '{0, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 4'b0001};
    vecs[1] = '{3, 1'b1, 32'h20, 32'hCAFEF00D, 32'h0,        4'b1000};
    vecs[2] = '{0, 1'b0, 32'h20, 32'h0,        32'hCAFEF00D, 4'b0001};
    vecs[3] = '{2, 1'b1, 32'h44, 32'h12345678, 32'h0,        4'b0100};
    vecs[4] = '{1, 1'b0, 32'h44, 32'h0,        32'h12345678, 4'b0010};

    // ---- reset state; requests during reset must not issue or stall ----
    repeat (2) drive_edge();
    bus.req = 4'b1111;
    @(negedge clk);
    chk("rst_mem_en", bus.mem_en, 0);
    chk("rst_stall", bus.stall, 0);
    chk("rst_ack", bus.ack, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_state", 64'(dbg.state), 64'(IDLE));
    chk("rst_rr_ptr", dbg.rr_ptr, 0);
    chk("rst_inflight", dbg.inflight, 0);
    drive_edge();
    bus.req = '0;
    reset = 1'b0;

    // ---- table-driven single accesses ----
    for (int v = 0; v < 5; v++) begin
      drive_edge();
      set_core(vecs[v].core, vecs[v].we, vecs[v].addr, vecs[v].wdata);
      @(negedge clk);
      chk("tbl_issue_en", bus.mem_en, 1);
      chk("tbl_issue_we", bus.mem_we, vecs[v].we);
      chk("tbl_issue_addr", bus.mem_addr, vecs[v].addr);
      if (vecs[v].we) chk("tbl_issue_wdata", bus.mem_wdata, vecs[v].wdata);
      chk("tbl_issue_stall", bus.stall, 1);
      chk("tbl_issue_ack", bus.ack, 0);
      drive_edge();
      @(negedge clk);
      chk("tbl_ack", bus.ack, vecs[v].exp_ack);
      if (!vecs[v].we) chk("tbl_rdata", bus.rdata, vecs[v].exp_rdata);
      chk("tbl_ack_stall", bus.stall, 0);
      chk("tbl_ack_mem_en", bus.mem_en, 0);
      drive_edge();
      bus.req[2'(vecs[v].core)] = 1'b0;
      @(negedge clk);
      chk("tbl_idle_ack", bus.ack, 0);
      chk("tbl_idle_rdata", bus.rdata, 0);
      chk("tbl_idle_mem_en", bus.mem_en, 0);
      chk("tbl_idle_hold_addr", bus.mem_addr, vecs[v].addr);
      chk("tbl_idle_stall", bus.stall, 0);
    end

    // ---- four simultaneous writes from rr_ptr = 0 ----
    do_reset();
    drive_edge();
    for (int i = 0; i < 4; i++) set_core(i, 1'b1, 32'(4 * i), 32'(i + 1));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("all4_mem_en", bus.mem_en, (k < 4));
      if (k < 4) begin
        chk("all4_mem_addr", bus.mem_addr, 4 * k);
        chk("all4_mem_wdata", bus.mem_wdata, k + 1);
        chk("all4_mem_we", bus.mem_we, 1);
      end
      chk("all4_ack", bus.ack, onehot(k - 1));
      chk("all4_stall", bus.stall, (k < 4));
      drive_edge();
      if (k > 0) bus.req[2'(k - 1)] = 1'b0;
    end

    // ---- core1 re-requests, core2 continuous: grants alternate ----
    set_core(1, 1'b0, 32'h100, 32'h0);
    set_core(2, 1'b0, 32'h200, 32'h0);
    for (int c = 0; c < 8; c++) begin
      logic [3:0] a;
      @(negedge clk);
      chk("alt_mem_en", bus.mem_en, 1);
      chk("alt_mem_addr", bus.mem_addr, ((c % 2 == 0) ? 32'h100 : 32'h200) + 32'(4 * (c / 2)));
      chk("alt_ack", bus.ack, (c == 0) ? 4'b0000 : onehot((c % 2 == 0) ? 2 : 1));
      a = bus.ack;
      drive_edge();
      if (a[1]) bus.addr[1] = bus.addr[1] + 32'h4;
      if (a[2]) bus.addr[2] = bus.addr[2] + 32'h4;
    end
    // core2 is in flight; dropping req early must still see its ack
    bus.req = '0;
    @(negedge clk);
    chk("early_drop_ack", bus.ack, 4'b0100);
    chk("early_drop_mem_en", bus.mem_en, 0);
    repeat (2) drive_edge();

    // ---- reset in the cycle after core2 issues ----
    set_core(2, 1'b0, 32'h50, 32'h0);
    @(negedge clk);
    chk("rstacc_issue", bus.mem_en, 1);
    chk("rstacc_issue_addr", bus.mem_addr, 32'h50);
    drive_edge();
    reset = 1'b1;
    @(negedge clk);
    chk("rstacc_ack", bus.ack, 0);
    chk("rstacc_rdata", bus.rdata, 0);
    chk("rstacc_stall", bus.stall, 0);
    chk("rstacc_mem_en", bus.mem_en, 0);
    drive_edge();
    reset = 1'b0;
    bus.req = '0;
    @(negedge clk);
    chk("rstacc_after_ack", bus.ack, 0);
    chk("rstacc_after_mem_en", bus.mem_en, 0);
    chk("rstacc_after_rr_ptr", dbg.rr_ptr, 0);
    chk("rstacc_after_state", 64'(dbg.state), 64'(IDLE));
    chk("rstacc_after_mem_addr", bus.mem_addr, 0);

    // ---- single-core instance: one access every two cycles ----
    drive_edge();
    bus1.req[0] = 1'b1;
    bus1.addr[0] = 32'h40;
    for (int c = 0; c < 8; c++) begin
      logic [31:0] a_exp;
      a_exp = 32'h40 + 32'(4 * (c / 2));
      @(negedge clk);
      if (c % 2 == 0) begin
        chk("c1_mem_en", bus1.mem_en, 1);
        chk("c1_mem_addr", bus1.mem_addr, a_exp);
        chk("c1_ack", bus1.ack, 0);
        chk("c1_stall", bus1.stall, 1);
      end else begin
        chk("c1_gap_mem_en", bus1.mem_en, 0);
        chk("c1_ack", bus1.ack, 1);
        chk("c1_rdata", bus1.rdata, 32'hA500_0000 | a_exp);
        chk("c1_ack_stall", bus1.stall, 0);
      end
      drive_edge();
      if (c % 2 == 1) bus1.addr[0] = bus1.addr[0] + 32'h4;
    end
    bus1.req = '0;

    // ---- randomized traffic against the reference model ----
    do_reset();
    m_ptr = 0; m_prev = -1; m_prev_we = 1'b0;
    m_last_addr = 32'h0; m_last_wdata = 32'h0;
    for (int i = 0; i < 8; i++) model_mem[i] = 32'h0;
    for (int i = 0; i < 4; i++) skips[i] = 0;
    max_skip = 0;
    ack_seen = '0;
    for (int cyc = 0; cyc < 460; cyc++) begin
      logic [3:0] exp_ack;
      logic [3:0] elig;
      int win;
      if (cyc > 0) drive_edge();
      for (int i = 0; i < 4; i++) begin
        if (bus.req[2'(i)] && ack_seen[2'(i)]) bus.req[2'(i)] = 1'b0;
        if (!bus.req[2'(i)] && cyc < 420 && $urandom_range(0, 2) == 0)
          set_core(i, 1'($urandom_range(0, 1)), 32'h300 + 32'(4 * $urandom_range(0, 7)), $urandom);
      end
      @(negedge clk);
      exp_ack = onehot(m_prev);
      chk("rnd_ack", bus.ack, exp_ack);
      if (m_prev >= 0 && !m_prev_we) begin
        if (exp_q.size() == 0) chk("rnd_exp_q_underflow", 1, 0);
        else chk("rnd_rdata", bus.rdata, exp_q.pop_front());
      end else if (m_prev < 0) begin
        chk("rnd_rdata_idle", bus.rdata, 0);
      end
      chk("rnd_stall", bus.stall, |(bus.req & ~exp_ack));
      elig = bus.req & ~exp_ack;
      win = -1;
      for (int k = 0; k < 4; k++) begin
        int j;
        j = (m_ptr + k) % 4;
        if (win < 0 && elig[2'(j)]) win = j;
      end
      chk("rnd_mem_en", bus.mem_en, (win >= 0));
      if (win >= 0) begin
        logic [31:0] a;
        a = bus.addr[2'(win)];
        chk("rnd_mem_we", bus.mem_we, bus.we[2'(win)]);
        chk("rnd_mem_addr", bus.mem_addr, a);
        if (bus.we[2'(win)]) begin
          chk("rnd_mem_wdata", bus.mem_wdata, bus.wdata[2'(win)]);
          model_mem[a[4:2]] = bus.wdata[2'(win)];
        end else begin
          exp_q.push_back(model_mem[a[4:2]]);
        end
        m_last_addr = a;
        m_last_wdata = bus.wdata[2'(win)];
        m_ptr = (win + 1) % 4;
        for (int i = 0; i < 4; i++) begin
          if (i == win) skips[i] = 0;
          else if (elig[2'(i)]) begin
            skips[i]++;
            if (skips[i] > max_skip) max_skip = skips[i];
          end
        end
        m_prev_we = bus.we[2'(win)];
      end else begin
        chk("rnd_idle_mem_we", bus.mem_we, 0);
        chk("rnd_hold_addr", bus.mem_addr, m_last_addr);
        chk("rnd_hold_wdata", bus.mem_wdata, m_last_wdata);
        m_prev_we = 1'b0;
      end
      m_prev = win;
      ack_seen = bus.ack;
    end
    chk("rnd_drained", bus.req, 0);
    chk("rnd_exp_q_empty", exp_q.size(), 0);
    chk("rnd_no_starvation", (max_skip <= 3), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter CORES, default 4, giving the number of requesting cores (legal range 1..8).
REQ-002 The block SHALL have parameter ADDR_W, default 32, giving the data-memory address width.
REQ-003 The block SHALL have parameter DATA_W, default 32, giving the data word width.
REQ-004 Port clk  input  1  is the single clock; all state updates on its rising edge.
REQ-005 Port reset  input  1  is a synchronous, active-high reset sampled on the rising edge of clk.
REQ-006 Port req  input  CORES  holds one bit per core, high while that core has a memory access pending.
REQ-007 Port we  input  CORES  holds one bit per core: 1 = write, 0 = read.
REQ-008 Port addr  input  CORES x ADDR_W  carries the per-core access address.
REQ-009 Port wdata  input  CORES x DATA_W  carries the per-core write data.
REQ-010 Port ack  output  CORES  is a one-cycle pulse per core marking completion of its access.
REQ-011 Port rdata  output  DATA_W  carries read data, valid in the cycle where ack is high for a read.
REQ-012 Port stall  output  1  is high while any core has req high and ack low; it holds the shared pc.
REQ-013 Port mem_en  output  1  is the memory access strobe.
REQ-014 Port mem_we  output  1  is the memory write enable.
REQ-015 Port mem_addr  output  ADDR_W  is the memory address.
REQ-016 Port mem_wdata  output  DATA_W  is the memory write data.
REQ-017 Port mem_rdata  input  DATA_W  is the memory read data, registered by the memory one cycle after mem_en.

Function
REQ-018 Requesters SHALL hold req, we, addr and wdata stable from assertion until the cycle in which their ack is high, and SHALL deassert req in the following cycle unless they start a new access.
REQ-019 The arbiter SHALL use an FSM with two states: IDLE (no access in flight) and ACCESS (an access was issued in the previous cycle).
REQ-020 Eligible set = req & ~inflight_mask, where inflight_mask is one-hot on the core issued in the previous cycle (all zeros in IDLE).
REQ-021 In any cycle with a non-empty eligible set, the winner SHALL be the first eligible core at or after rr_ptr, searching upward with wrap from CORES-1 to 0.
REQ-022 On issue, the arbiter SHALL drive the winner's we, addr and wdata on mem_we, mem_addr and mem_wdata with mem_en=1 in that same cycle (combinational issue path), register the winner index, and set rr_ptr to (winner+1) mod CORES.
REQ-023 Transitions: IDLE->ACCESS on issue; ACCESS->ACCESS on issue; ACCESS->IDLE when the eligible set is empty; IDLE->IDLE otherwise.
REQ-024 In ACCESS, ack[registered winner] SHALL be 1 and rdata SHALL equal mem_rdata; all other ack bits SHALL be 0.
REQ-025 Latency SHALL be exactly one cycle from issue to ack; throughput SHALL be one access per cycle under back-to-back requests.
REQ-026 When not issuing, mem_en=0 and mem_we=0; mem_addr and mem_wdata SHALL hold their last values.
REQ-027 rdata SHALL be 0 in any cycle where no ack is high.
REQ-028 A write and a subsequent read to the same address SHALL return the written data (memory is single-ported and accesses are serialised).
REQ-029 A req deasserted before its ack is a protocol violation; the arbiter SHALL still complete and ack any access it has already issued.

Reset
REQ-030 On reset: state=IDLE, rr_ptr=0, inflight_mask=0, ack=0, rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-031 Reset asserted in ACCESS SHALL suppress the pending ack; the in-flight access is abandoned and not re-issued.
REQ-032 While reset is high, stall SHALL be 0 and no access SHALL issue.

Structure
REQ-033 The FSM state enum, CORES default and the core-index width constant ($clog2(CORES), minimum 1) SHALL live in the shared cpu_pkg package.
REQ-034 Round-robin winner selection SHALL be a separate combinational sub-module rr_picker (inputs eligible and rr_ptr; outputs valid and winner index).

Verification
REQ-035 Core0 reads 0x10, memory holds 0xDEADBEEF at 0x10 -> mem_en=1 at cycle N; ack=0001 and rdata=0xDEADBEEF at N+1; stall=1 only in cycle N.
REQ-036 All four cores write (addr 0x0,0x4,0x8,0xC; data 1,2,3,4) in the same cycle from rr_ptr=0 -> issue order 0,1,2,3 in consecutive cycles; acks 0001,0010,0100,1000; stall high 4 cycles.
REQ-037 Core1 re-requests immediately after each ack while core2 requests continuously -> grants alternate 1,2,1,2 with no core starved more than CORES-1 issues.
REQ-038 Core3 writes 0xCAFEF00D to 0x20, then core0 reads 0x20 -> core0 rdata=0xCAFEF00D.
REQ-039 Reset asserted in the cycle after core2 issues -> no ack observed, rr_ptr=0, mem_en=0 in the following cycle.
REQ-040 CORES=1: a single core performs back-to-back reads -> one access every two cycles (in-flight mask) with correct rdata.
